bpu_update_queue: RTL and testbench

- Sits directly downstream of the integer writeback pipeline register. Consumes the registered BHT/BTB training requests emitted by the branch unit (intwb_bjusb_*).
- Buffers them in a small FIFO and drains one entry per cycle into the branch predictor's BHT/BTB write ports. Draining happens only when the predictor grants a write slot, because fetch-side reads take priority.
- Writeback cannot stall, so requests arriving while the FIFO is full are dropped and counted.

---
 rtl/bpu_update_queue_pkg.sv | 50 +++++
 rtl/bpu_update_queue_fifo.sv | 58 +++++
 rtl/bpu_update_queue.sv | 124 ++++++++++++
 tb/tb_bpu_update_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_update_queue_pkg.sv
// Shared types and widths for the branch predictor update queue.
// BHT and BTB training fields are carried together as one queue entry.
`ifndef BHTBTB_INDEX_WIDTH
`define BHTBTB_INDEX_WIDTH 10
`endif

package bpu_update_queue_pkg;

    localparam int BHT_IDX_W = `BHTBTB_INDEX_WIDTH;
    localparam int BTB_IDX_W = 9;
    localparam int BTB_W     = 129;

    typedef struct packed {
        logic                 write_enable;
        logic [BHT_IDX_W-1:0] write_index;
        logic [1:0]           counter_select;
        logic                 inc;
        logic                 dec;
        logic                 valid_in;
    } bht_upd_t;

    typedef struct packed {
        logic                 ce;
        logic                 we;
        logic [BTB_W-1:0]     wmask;
        logic [BTB_IDX_W-1:0] write_index;
        logic [BTB_W-1:0]     din;
    } btb_upd_t;

    typedef struct packed {
        bht_upd_t bht;
        btb_upd_t btb;
    } bpu_upd_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    function automatic occ_e occ_of(input int count, input int depth);
        if (count == 0) begin
            return OCC_EMPTY;
        end else if (count >= depth) begin
            return OCC_FULL;
        end
        return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/bpu_update_queue_fifo.sv
// Generic synchronous FIFO; a push while full is ignored unless a pop frees
// a slot in the same cycle. Storage clears on reset so outputs are never X.
module sync_fifo_nodrop_flag #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bpu_update_queue.sv
// Buffers writeback BHT/BTB training requests and drains them into the
// predictor write ports whenever it grants a slot; overflow is dropped and counted.
module bpu_update_queue
    import bpu_update_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int BHT_IDX_W  = bpu_update_queue_pkg::BHT_IDX_W,
    parameter int BTB_IDX_W  = bpu_update_queue_pkg::BTB_IDX_W,
    parameter int BTB_W      = bpu_update_queue_pkg::BTB_W,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  intwb_bjusb_bht_write_enable,
    input  logic [BHT_IDX_W-1:0]  intwb_bjusb_bht_write_index,
    input  logic [1:0]            intwb_bjusb_bht_write_counter_select,
    input  logic                  intwb_bjusb_bht_write_inc,
    input  logic                  intwb_bjusb_bht_write_dec,
    input  logic                  intwb_bjusb_bht_valid_in,
    input  logic                  intwb_bjusb_btb_ce,
    input  logic                  intwb_bjusb_btb_we,
    input  logic [BTB_W-1:0]      intwb_bjusb_btb_wmask,
    input  logic [BTB_IDX_W-1:0]  intwb_bjusb_btb_write_index,
    input  logic [BTB_W-1:0]      intwb_bjusb_btb_din,
    input  logic                  bpu_upd_ready,
    output logic                  bpu_upd_valid,
    output logic                  bpu_bht_write_enable,
    output logic [BHT_IDX_W-1:0]  bpu_bht_write_index,
    output logic [1:0]            bpu_bht_write_counter_select,
    output logic                  bpu_bht_write_inc,
    output logic                  bpu_bht_write_dec,
    output logic                  bpu_bht_valid_in,
    output logic                  bpu_btb_ce,
    output logic                  bpu_btb_we,
    output logic [BTB_W-1:0]      bpu_btb_wmask,
    output logic [BTB_IDX_W-1:0]  bpu_btb_write_index,
    output logic [BTB_W-1:0]      bpu_btb_din,
    output logic                  upd_queue_full,
    output logic [DROP_CNT_W-1:0] upd_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = $bits(bpu_upd_entry_t);

    bpu_upd_entry_t        w_in_entry;
    bpu_upd_entry_t        w_head_raw;
    bpu_upd_entry_t        w_head;
    logic [EW-1:0]         w_fifo_dout;
    logic                  w_btb_wr;
    logic                  w_enq_req;
    logic                  w_deq;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [AW:0]           w_count;
    occ_e                  w_occ;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // A BTB read (ce without we) is not training, so only ce&we qualifies.
    assign w_btb_wr  = intwb_bjusb_btb_ce & intwb_bjusb_btb_we;
    assign w_enq_req = intwb_bjusb_bht_write_enable | w_btb_wr;

    always_comb begin
        w_in_entry                    = '0;
        w_in_entry.bht.write_enable   = intwb_bjusb_bht_write_enable;
        w_in_entry.bht.write_index    = intwb_bjusb_bht_write_index;
        w_in_entry.bht.counter_select = intwb_bjusb_bht_write_counter_select;
        w_in_entry.bht.inc            = intwb_bjusb_bht_write_inc;
        w_in_entry.bht.dec            = intwb_bjusb_bht_write_dec;
        w_in_entry.bht.valid_in       = intwb_bjusb_bht_valid_in;
        w_in_entry.btb.ce             = w_btb_wr;
        w_in_entry.btb.we             = w_btb_wr;
        w_in_entry.btb.wmask          = intwb_bjusb_btb_wmask;
        w_in_entry.btb.write_index    = intwb_bjusb_btb_write_index;
        w_in_entry.btb.din            = intwb_bjusb_btb_din;
    end

    sync_fifo_nodrop_flag #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_enq_req),
        .i_pop   (w_deq),
        .i_din   (w_in_entry),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bpu_upd_valid = ~w_empty;
    assign w_deq         = bpu_upd_valid & bpu_upd_ready;
    assign w_drop        = w_enq_req & w_full & ~w_deq;
    assign w_head_raw    = w_fifo_dout;
    assign w_head        = bpu_upd_valid ? w_head_raw : '0;

    assign w_occ          = occ_of(int'(w_count), DEPTH);
    assign upd_queue_full = (w_occ == OCC_FULL);

    assign bpu_bht_write_enable         = w_head.bht.write_enable;
    assign bpu_bht_write_index          = w_head.bht.write_index;
    assign bpu_bht_write_counter_select = w_head.bht.counter_select;
    assign bpu_bht_write_inc            = w_head.bht.inc;
    assign bpu_bht_write_dec            = w_head.bht.dec;
    assign bpu_bht_valid_in             = w_head.bht.valid_in;
    assign bpu_btb_ce                   = w_head.btb.ce;
    assign bpu_btb_we                   = w_head.btb.we;
    assign bpu_btb_wmask                = w_head.btb.wmask;
    assign bpu_btb_write_index          = w_head.btb.write_index;
    assign bpu_btb_din                  = w_head.btb.din;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign upd_drop_count = r_drop_cnt;

endmodule

// File: tb/tb_bpu_update_queue.sv
// Scoreboard bench for bpu_update_queue: the driver queues expected entries,
// a negedge monitor compares the presented head and pops on handshake.
module tb_bpu_update_queue;
    import bpu_update_queue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 4;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bpu_upd_entry_t in_e = '0;
    logic           rdy  = 1'b0;

    logic                 bpu_upd_valid, upd_queue_full;
    logic                 o_bht_we, o_bht_inc, o_bht_dec, o_bht_vin;
    logic [BHT_IDX_W-1:0] o_bht_idx;
    logic [1:0]           o_bht_sel;
    logic                 o_btb_ce, o_btb_we;
    logic [BTB_W-1:0]     o_btb_wmask, o_btb_din;
    logic [BTB_IDX_W-1:0] o_btb_idx;
    logic [DROP_W-1:0]    upd_drop_count;

    bpu_update_queue #(
        .DEPTH      (DEPTH),
        .DROP_CNT_W (DROP_W)
    ) dut (
        .clock                                (clock),
        .reset                                (reset),
        .intwb_bjusb_bht_write_enable         (in_e.bht.write_enable),
        .intwb_bjusb_bht_write_index          (in_e.bht.write_index),
        .intwb_bjusb_bht_write_counter_select (in_e.bht.counter_select),
        .intwb_bjusb_bht_write_inc            (in_e.bht.inc),
        .intwb_bjusb_bht_write_dec            (in_e.bht.dec),
        .intwb_bjusb_bht_valid_in             (in_e.bht.valid_in),
        .intwb_bjusb_btb_ce                   (in_e.btb.ce),
        .intwb_bjusb_btb_we                   (in_e.btb.we),
        .intwb_bjusb_btb_wmask                (in_e.btb.wmask),
        .intwb_bjusb_btb_write_index          (in_e.btb.write_index),
        .intwb_bjusb_btb_din                  (in_e.btb.din),
        .bpu_upd_ready                        (rdy),
        .bpu_upd_valid                        (bpu_upd_valid),
        .bpu_bht_write_enable                 (o_bht_we),
        .bpu_bht_write_index                  (o_bht_idx),
        .bpu_bht_write_counter_select         (o_bht_sel),
        .bpu_bht_write_inc                    (o_bht_inc),
        .bpu_bht_write_dec                    (o_bht_dec),
        .bpu_bht_valid_in                     (o_bht_vin),
        .bpu_btb_ce                           (o_btb_ce),
        .bpu_btb_we                           (o_btb_we),
        .bpu_btb_wmask                        (o_btb_wmask),
        .bpu_btb_write_index                  (o_btb_idx),
        .bpu_btb_din                          (o_btb_din),
        .upd_queue_full                       (upd_queue_full),
        .upd_drop_count                       (upd_drop_count)
    );

    bpu_upd_entry_t act;
    always_comb begin
        act = '0;
        act.bht.write_enable   = o_bht_we;
        act.bht.write_index    = o_bht_idx;
        act.bht.counter_select = o_bht_sel;
        act.bht.inc            = o_bht_inc;
        act.bht.dec            = o_bht_dec;
        act.bht.valid_in       = o_bht_vin;
        act.btb.ce             = o_btb_ce;
        act.btb.we             = o_btb_we;
        act.btb.wmask          = o_btb_wmask;
        act.btb.write_index    = o_btb_idx;
        act.btb.din            = o_btb_din;
    end

    bpu_upd_entry_t sb[$];
    int  m_cnt = 0;
    int  m_drop_sat = 0;
    int  n_req = 0, n_acc = 0, n_drop = 0, n_popped = 0;
    int  n_checks = 0, n_fail = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [299:0] a, input logic [299:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && mon_en) begin
            chk("valid", 300'(bpu_upd_valid), 300'(m_cnt != 0));
            chk("full", 300'(upd_queue_full), 300'(m_cnt == DEPTH));
            chk("drop_count", 300'(upd_drop_count), 300'(m_drop_sat));
            if (bpu_upd_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 300'(1), 300'(0));
                end else begin
                    chk("head", 300'(act), 300'(sb[0]));
                    if (rdy) begin
                        void'(sb.pop_front());
                        n_popped++;
                    end
                end
            end else begin
                chk("idle_enables", 300'({o_bht_we, o_btb_ce, o_btb_we}), 300'(0));
            end
        end
    end

    // Called at posedge+1; leaves time at the following posedge+1.
    task automatic step(input logic bht, input logic ce, input logic we, input logic r);
        bit req, deq, acc;
        bpu_upd_entry_t exp;
        in_e.bht.write_enable = bht;
        in_e.btb.ce = ce;
        in_e.btb.we = we;
        rdy = r;
        req = bht | (ce & we);
        deq = (m_cnt != 0) && r;
        acc = req && ((m_cnt < DEPTH) || deq);
        @(posedge clock);
        if (req) n_req++;
        if (acc) begin
            exp = in_e;
            exp.btb.ce = ce & we;
            exp.btb.we = ce & we;
            sb.push_back(exp);
            n_acc++;
        end else if (req) begin
            n_drop++;
            if (m_drop_sat < DROP_MAX) m_drop_sat++;
        end
        m_cnt = m_cnt + (acc ? 1 : 0) - (deq ? 1 : 0);
        #1;
    endtask

    task automatic set_bht(input int idx, input int sel, input bit inc, input bit dec);
        in_e = '0;
        in_e.bht.write_index    = BHT_IDX_W'(idx);
        in_e.bht.counter_select = 2'(sel);
        in_e.bht.inc            = inc;
        in_e.bht.dec            = dec;
        in_e.bht.valid_in       = 1'b1;
    endtask

    initial begin
        logic [159:0] rnd;
        int kind;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 300'(bpu_upd_valid), 300'(0));
        chk("rst_full", 300'(upd_queue_full), 300'(0));
        chk("rst_drop", 300'(upd_drop_count), 300'(0));
        chk("rst_outputs", 300'(act), 300'(0));
        reset = 1'b0;
        mon_en = 1'b1;

        // single BHT update
        set_bht(5, 2, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("bht_we", 300'(o_bht_we), 300'(1));
        chk("bht_idx", 300'(o_bht_idx), 300'(5));
        chk("bht_sel", 300'(o_bht_sel), 300'(2));
        chk("bht_btb_ce", 300'(o_btb_ce), 300'(0));
        in_e = '0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bht_drained", 300'(bpu_upd_valid), 300'(0));

        // fill with ready low, fifth request dropped
        for (int i = 1; i <= 5; i++) begin
            set_bht(i, i % 4, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 4) chk("full_after4", 300'(upd_queue_full), 300'(1));
        end
        chk("drop_after5", 300'(upd_drop_count), 300'(1));

        // full queue: push and pop in the same cycle
        set_bht(6, 3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("full_pushpop_full", 300'(upd_queue_full), 300'(1));
        chk("full_pushpop_drop", 300'(upd_drop_count), 300'(1));
        chk("full_pushpop_head", 300'(o_bht_idx), 300'(2));
        in_e = '0;
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);

        // BTB-only write, then a BTB read which must be ignored
        in_e = '0;
        in_e.btb.write_index = 9'h1A3;
        in_e.btb.din   = 129'h1_DEADBEEF_CAFEF00D_01234567_89ABCDEF;
        in_e.btb.wmask = '1;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("btb_we", 300'(o_btb_we), 300'(1));
        chk("btb_bht_we", 300'(o_bht_we), 300'(0));
        chk("btb_idx", 300'(o_btb_idx), 300'(9'h1A3));
        chk("btb_din", 300'(o_btb_din), 300'(129'h1_DEADBEEF_CAFEF00D_01234567_89ABCDEF));
        chk("btb_read_not_queued", 300'(m_cnt), 300'(1));
        in_e = '0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // reset while three entries are queued and ready is high
        for (int i = 0; i < 3; i++) begin
            set_bht(16 + i, 1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        in_e = '0;
        rdy = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", 300'(bpu_upd_valid), 300'(0));
        chk("midrst_full", 300'(upd_queue_full), 300'(0));
        chk("midrst_drop", 300'(upd_drop_count), 300'(0));
        chk("midrst_outputs", 300'(act), 300'(0));
        sb.delete();
        m_cnt = 0;
        m_drop_sat = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        set_bht(9'h0AA, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("postrst_valid", 300'(bpu_upd_valid), 300'(1));
        chk("postrst_idx", 300'(o_bht_idx), 300'(9'h0AA));
        in_e = '0;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // random traffic with random ready
        n_req = 0; n_acc = 0; n_drop = 0; n_popped = 0;
        for (int i = 0; i < 200; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_e.bht.write_index    = BHT_IDX_W'($urandom);
            in_e.bht.counter_select = 2'($urandom);
            in_e.bht.inc            = 1'($urandom);
            in_e.bht.dec            = 1'($urandom);
            in_e.bht.valid_in       = 1'($urandom);
            in_e.btb.wmask          = rnd[128:0];
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_e.btb.din            = rnd[128:0];
            in_e.btb.write_index    = BTB_IDX_W'($urandom);
            kind = $urandom_range(0, 3);
            case (kind)
                0:       step(1'b1, 1'b0, 1'($urandom), ($urandom_range(0, 9) < 4));
                1:       step(1'b0, 1'b1, 1'b1, ($urandom_range(0, 9) < 4));
                2:       step(1'b1, 1'b1, 1'b1, ($urandom_range(0, 9) < 4));
                default: step(1'b0, 1'b1, 1'b0, ($urandom_range(0, 9) < 4));
            endcase
        end
        in_e = '0;
        repeat (DEPTH + 2) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rand_drained_eq_accepted", 300'(n_popped), 300'(n_acc));
        chk("rand_sb_empty", 300'(sb.size()), 300'(0));
        chk("rand_final_valid", 300'(bpu_upd_valid), 300'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
